// File: rtl/plab1_idiv_int_div_var_lat_pkg.sv
// Shared message layout, FSM state encodings and datapath mux selects for the
// iterative unsigned divider.
package plab1_idiv_msgs;

  localparam int NBITS_DEF = 32;

  // Request is {a, b}, response is {quotient, remainder}; both are 2*NBITS wide.
  localparam int REQ_A_MSB = 2*NBITS_DEF-1;
  localparam int REQ_A_LSB = NBITS_DEF;
  localparam int REQ_B_MSB = NBITS_DEF-1;
  localparam int REQ_B_LSB = 0;
  localparam int RESP_Q_MSB = 2*NBITS_DEF-1;
  localparam int RESP_Q_LSB = NBITS_DEF;
  localparam int RESP_R_MSB = NBITS_DEF-1;
  localparam int RESP_R_LSB = 0;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_ITER = 2'd2,
    SEL_SKIP = 2'd3
  } dp_sel_e;

endpackage

// File: rtl/plab1_idiv_int_div_var_lat_if.sv
// val/rdy request/response bundle shared by the divider and its clients.
interface plab1_idiv_int_div_var_lat_if #(parameter int NBITS = 32);
  logic               in_val;
  logic               in_rdy;
  logic [2*NBITS-1:0] in_msg;
  logic               out_val;
  logic               out_rdy;
  logic [2*NBITS-1:0] out_msg;

  modport master (output in_val, in_msg, out_rdy, input in_rdy, out_val, out_msg);
  modport slave  (input in_val, in_msg, out_rdy, output in_rdy, out_val, out_msg);
endinterface

// File: rtl/plab1_idiv_int_div_var_lat_ctrl.sv
// Divider control: IDLE/CALC/DONE FSM, iteration counter and handshake outputs.
module plab1_idiv_int_div_var_lat_ctrl
  import plab1_idiv_msgs::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  input  logic          out_rdy,
  input  logic          skip,
  input  logic [CW-1:0] cnt_init,
  output logic          in_rdy,
  output logic          out_val,
  output dp_sel_e       sel
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = SEL_HOLD;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    unique case (state_q)
      STATE_IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          if (skip) begin
            sel     = SEL_SKIP;
            state_d = STATE_DONE;
          end else begin
            sel     = SEL_LOAD;
            cnt_d   = cnt_init;
            state_d = STATE_CALC;
          end
        end
      end
      STATE_CALC: begin
        sel   = SEL_ITER;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = STATE_DONE;
      end
      STATE_DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase
  end

endmodule

// File: rtl/plab1_idiv_int_div_var_lat.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Optional macro PLAB1_IDIV_SKIP_ZEROS_EN skips leading zeros of the dividend.
module plab1_idiv_int_div_var_lat
  import plab1_idiv_msgs::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sd,
  plab1_idiv_int_div_var_lat_if.slave   io
);

  localparam int CW = $clog2(NBITS+1);

  logic [NBITS-1:0] a, b;
  logic [NBITS-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [NBITS-1:0] quo_ld;
  logic [NBITS:0]   rem_sh, diff;
  logic [CW-1:0]    cnt_init;
  logic             skip;
  dp_sel_e          sel;

  // Every signal is tagged with the same domain; no per-domain state is kept.
  logic unused_sd;
  assign unused_sd = sd;

  assign a = io.in_msg[2*NBITS-1:NBITS];
  assign b = io.in_msg[NBITS-1:0];

`ifdef PLAB1_IDIV_SKIP_ZEROS_EN
  logic [CW-1:0] lz;
  always_comb begin
    lz = CW'(NBITS);
    for (int i = 0; i < NBITS; i++)
      if (a[i]) lz = CW'(NBITS-1-i);
  end
  assign cnt_init = CW'(NBITS) - lz;
  assign quo_ld   = a << lz;
  // b==0 and a==0 both have closed-form results, so bypass CALC entirely.
  assign skip     = (a == '0) || (b == '0);
`else
  assign cnt_init = CW'(NBITS);
  assign quo_ld   = a;
  assign skip     = 1'b0;
`endif

  plab1_idiv_int_div_var_lat_ctrl #(.CW(CW)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .in_val  (io.in_val),
    .out_rdy (io.out_rdy),
    .skip    (skip),
    .cnt_init(cnt_init),
    .in_rdy  (io.in_rdy),
    .out_val (io.out_val),
    .sel     (sel)
  );

  // Shifted remainder keeps the carried-out bit so the compare is NBITS+1 wide.
  assign rem_sh = {rem_q, quo_q[NBITS-1]};
  assign diff   = rem_sh - {1'b0, div_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    unique case (sel)
      SEL_LOAD: begin
        rem_d = '0;
        quo_d = quo_ld;
        div_d = b;
      end
      SEL_ITER: begin
        quo_d = {quo_q[NBITS-2:0], ~diff[NBITS]};
        rem_d = diff[NBITS] ? rem_sh[NBITS-1:0] : diff[NBITS-1:0];
      end
      SEL_SKIP: begin
        div_d = b;
        quo_d = (b == '0) ? '1 : '0;
        rem_d = (b == '0) ? a  : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

  assign io.out_msg = {quo_q, rem_q};

  a_ctl_known: assert property (@(posedge clk)
    reset |-> !$isunknown({io.in_val, io.in_rdy, io.out_val, io.out_rdy}));

endmodule

// File: tb/tb_plab1_idiv_int_div_var_lat.sv
// Randomized scoreboard bench for the iterative divider; latency expectations
// follow PLAB1_IDIV_SKIP_ZEROS_EN when it is defined.
module tb_plab1_idiv_int_div_var_lat;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sd = 1'b0;
  always #5 clk = ~clk;

  plab1_idiv_int_div_var_lat_if #(.NBITS(32)) ifc();

  plab1_idiv_int_div_var_lat dut (
    .clk  (clk),
    .reset(reset),
    .sd   (sd),
    .io   (ifc)
  );

  int total = 0;
  int bad = 0;
  int n_resp = 0;
  logic [63:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [63:0] prev_msg = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef PLAB1_IDIV_SKIP_ZEROS_EN
    int n = 0;
    if (b == 0 || a == 0) return 1;
    while (n < 32 && !a[31-n]) n++;
    return 32 - n + 1;
`else
    return 33;
`endif
  endfunction

  // Monitor: pushes expected results on accepted requests, pops on responses.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_val", {63'd0, ifc.out_val}, 64'd1);
        chk("hold_msg", ifc.out_msg, prev_msg);
      end
      if (ifc.in_val && ifc.in_rdy)
        exp_q.push_back(model(ifc.in_msg[63:32], ifc.in_msg[31:0]));
      if (ifc.out_val && ifc.out_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got %0h want none", ifc.out_msg);
        end else begin
          chk("resp", ifc.out_msg, exp_q.pop_front());
        end
        n_resp++;
      end
      prev_hold = ifc.out_val && !ifc.out_rdy;
      prev_msg  = ifc.out_msg;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    ifc.in_val = 1'b1;
    ifc.in_msg = {a, b};
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (ifc.in_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail("send");
      ifc.in_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifc.in_val = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!ifc.out_val && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!ifc.out_val) fail("wait_resp");
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b);
    int lat;
    send(a, b);
    wait_resp(lat);
    chk("latency", 64'(lat), 64'(exp_lat(a, b)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int target;
    bit prod_done;
    logic [31:0] ra, rb;

    ifc.in_val  = 1'b0;
    ifc.in_msg  = '0;
    ifc.out_rdy = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
    chk("rst_out_val", {63'd0, ifc.out_val}, 64'd0);
    chk("rst_out_msg", ifc.out_msg, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
    chk("idle_out_val", {63'd0, ifc.out_val}, 64'd0);
    @(posedge clk);
    #1;

    run_one(32'd100, 32'd7);
    run_one(32'hFFFF_FFFF, 32'd1);
    run_one(32'd5, 32'd0);
    run_one(32'd0, 32'd9);
    run_one(32'd0, 32'd0);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_one(32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // Sink stall: the result must sit still with the request side closed.
    ifc.out_rdy = 1'b0;
    send(32'd3, 32'd10);
    wait_resp(lat);
    for (int k = 0; k < 5; k++) begin
      chk("stall_msg", ifc.out_msg, {32'd0, 32'd3});
      chk("stall_in_rdy", {63'd0, ifc.in_rdy}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 ifc.out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_drain_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
    chk("post_drain_out_val", {63'd0, ifc.out_val}, 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC: the in-flight result must vanish.
    send(32'd200000, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
    chk("midrst_out_val", {63'd0, ifc.out_val}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    begin
      bit seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (ifc.out_val) seen = 1;
      end
      chk("no_stale_resp", {63'd0, seen}, 64'd0);
    end
    @(posedge clk);
    #1;
    run_one(32'd81, 32'd9);

    // Random back-to-back stream with a randomly stalling sink.
    target = n_resp + 50;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          ra = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 9) == 0) ra = 0;
          case ($urandom_range(0, 3))
            0: rb = 0;
            1: rb = $urandom;
            2: rb = $urandom >> $urandom_range(8, 31);
            default: rb = $urandom_range(1, 20);
          endcase
          send(ra, rb);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        prod_done = 1;
      end
      begin
        int cyc = 0;
        while ((!prod_done || n_resp < target) && cyc < 20000) begin
          @(posedge clk);
          #1 ifc.out_rdy = 1'($urandom_range(0, 1));
          cyc++;
        end
        if (n_resp < target) fail("stream_drain");
        ifc.out_rdy = 1'b1;
      end
    join
    @(negedge clk);
    chk("stream_count", 64'(n_resp), 64'(target));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plab1_idiv_int_div_var_lat.md
Name: plab1_idiv_int_div_var_lat

Overview:
- Iterative unsigned 32-bit integer divider. Produces quotient and remainder and sits behind the same val/rdy request/response interface as the multiplier unit.
- It is the inverse arithmetic unit of the variable-latency multiplier. Each request is a dividend/divisor pair; each response is a quotient/remainder pair.
- Restoring shift-subtract algorithm with a 3-state control FSM and a register datapath.
- Optional leading-zero skip makes latency depend on the operand.

Parameters:
- NBITS, 32, operand width. The request and response messages are each 2*NBITS wide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- sd  in  1  security-domain tag; all dataflow and control signals below belong to domain sd
- in_val  in  1  request valid
- in_rdy  out  1  request ready
- in_msg  in  2*NBITS  {a (dividend) [63:32], b (divisor) [31:0]}
- out_val  out  1  response valid
- out_rdy  in  1  response ready
- out_msg  out  2*NBITS  {quotient [63:32], remainder [31:0]}

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, counter=0, rem/quo/divisor registers=0.
  - Outputs during and after reset: in_rdy=1, out_val=0, out_msg=0.
  - Reset mid-CALC or mid-DONE aborts the operation; the in-flight result is discarded and never emitted.
- Handshakes:
  - in_go=in_val&&in_rdy; out_go=out_val&&out_rdy.
  - in_rdy=1 only in IDLE; out_val=1 only in DONE.
  - One transaction in flight; no request is accepted in the DONE cycle even if out_go.
  - out_msg is stable while out_val=1 and out_rdy=0.
- FSM:
  - IDLE: on in_go, load rem=0, quo=a, div=b, counter=NBITS, then go to CALC.
  - CALC, one iteration per cycle:
    - {rem,quo} shifted left by 1.
    - diff=rem_shifted-div, computed NBITS+1 wide.
    - If diff is non-negative: rem=diff[NBITS-1:0] and quo[0]=1. Otherwise rem=rem_shifted and quo[0]=0.
    - counter decrements each cycle; when counter==1 this cycle, go to DONE.
  - DONE: hold the result; on out_go go to IDLE.
- Latency (baseline): in_go in cycle 0; CALC runs cycles 1..32; out_val=1 from cycle 33. Fixed.
- Divide by zero:
  - Baseline behaviour falls out of the algorithm: quotient=0xFFFFFFFF, remainder=a.
  - This result is mandatory in both build configurations.
- a<b: quotient=0, remainder=a.
- No signed mode. Operands and results are unsigned only.
- Assertions: in_val, in_rdy, out_val and out_rdy are not X whenever reset==1.

Optional Feature:
- Macro: PLAB1_IDIV_SKIP_ZEROS_EN.
- Defined:
  - In IDLE, lz=count of leading zeros of a. Load quo=a<<lz and counter=NBITS-lz.
  - CALC runs NBITS-lz cycles; out_val=1 at cycle NBITS-lz+1 after in_go.
  - If a==0: go IDLE->DONE directly with {0,0}; out_val at cycle 1.
  - If b==0: go IDLE->DONE directly with {0xFFFFFFFF, a}; out_val at cycle 1. This case takes priority over a==0.
- Undefined: fixed 33-cycle latency for every request; no lz logic is instantiated.
- Results must be bit-identical in both builds.

Decomposition:
- Shared package plab1_idiv_msgs:
  - request/response field widths and bit slices (a/b, quotient/remainder);
  - state encodings STATE_IDLE=2'd0, STATE_CALC=2'd1, STATE_DONE=2'd2;
  - mux-select constants.
- Natural sub-module: plab1_idiv_int_div_var_lat_ctrl (FSM, counter-done and handshake outputs). The datapath stays in the top.
- The leading-zero count reuses the existing count-zeros block under the macro.

Test Plan:
- a=100, b=7 -> q=14, r=2. out_val at cycle 33 (baseline) or cycle 8 (lz=25, SKIP_ZEROS_EN).
- a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0. Latency 33 in both builds.
- a=5, b=0 -> q=0xFFFFFFFF, r=5. Latency 33 (baseline) or 1 (SKIP_ZEROS_EN). a=0, b=9 -> {0,0}.
- a=3, b=10 -> q=0, r=3. Hold out_rdy=0 for 5 cycles after out_val: out_msg stable, in_rdy=0 throughout. out_rdy=1 -> IDLE next cycle, in_rdy=1.
- Back-to-back streams: 50 random (a,b) pairs, sink randomly stalling -> every response matches the a/b, a%b reference (0xFFFFFFFF/a for b=0), in order.
- Assert reset=0 in cycle 10 of a CALC -> in_rdy=1, out_val=0 next cycle. No stale response appears; the next request a=81, b=9 -> q=9, r=0.
